// File: rtl/seg_display_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_driver_pkg
//   Shared constants and helpers for the seven-segment display driver.
//   - NUM_DIGITS / BIN_W / BCD_W : geometry of the display and the converter
//   - SEG_0..SEG_9, SEG_BLANK    : active-low segment patterns, dp off,
//                                  bit order [0]=a .. [6]=g, [7]=dp
//   - conv_state_e               : converter FSM state (exported for debug)
//   - seg_decode()               : BCD nibble -> segment pattern
//   - bcd_add3()                 : double-dabble "add 3 to every nibble >= 5"
// -----------------------------------------------------------------------------
package seg_display_driver_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BIN_W      = 24;
  localparam int BCD_W      = 32;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [0:0] {
    CONV_IDLE  = 1'b0,
    CONV_SHIFT = 1'b1
  } conv_state_e;

  // Nibbles 10..15 never come out of a correct BCD conversion; show them
  // blank rather than inventing a glyph.
  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    logic [7:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential double-dabble converter: one iteration per clock, BIN_W
//   iterations per conversion.
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     start      : request a conversion of `value` (honoured only when idle)
//     value      : unsigned binary input, BIN_W bits
//     busy       : high from the cycle after start until the result is out
//     done       : one-cycle pulse on the final iteration
//     bcd        : BCD result, valid only while done=1
//     state_dbg  : current FSM state
//
//   Handshake: start is a request sampled on a rising edge while the FSM is
//   idle; it is ignored while busy (there is no ready/back-pressure, the
//   caller re-evaluates start when busy drops). done/bcd form a one-cycle
//   valid strobe with no ready: the consumer must capture bcd on that edge.
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import seg_display_driver_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BIN_W-1:0]  value,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd,
  output conv_state_e       state_dbg
);

  localparam logic [4:0] LAST_STEP = 5'(BIN_W - 1);

  conv_state_e             state_q, state_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [4:0]              step_q, step_d;
  logic [BCD_W+BIN_W-1:0]  shifted;

  // One double-dabble iteration on the current shift register contents.
  always_comb begin
    shifted = {bcd_add3(bcd_q), bin_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    step_d  = step_q;
    done    = 1'b0;
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          bcd_d   = '0;
          bin_d   = value;
          step_d  = '0;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        bcd_d  = shifted[BCD_W+BIN_W-1:BIN_W];
        bin_d  = shifted[BIN_W-1:0];
        step_d = step_q + 5'd1;
        // The last iteration's result is handed out combinationally so the
        // consumer latches it on the same edge busy drops.
        if (step_q == LAST_STEP) begin
          done    = 1'b1;
          state_d = CONV_IDLE;
        end
      end
      default: begin
        state_d = CONV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      step_q  <= step_d;
    end
  end

  assign busy      = (state_q == CONV_SHIFT);
  assign bcd       = shifted[BCD_W+BIN_W-1:BIN_W];
  assign state_dbg = state_q;

endmodule

// File: rtl/seg_display_driver.sv
// -----------------------------------------------------------------------------
// seg_display_driver
//   Shows a 24-bit unsigned value in decimal on an 8-digit common-anode
//   seven-segment display. A new value is converted to BCD by bin2bcd_seq;
//   the finished BCD word is copied into digit_reg in one step, so the scan
//   never shows a half-converted number. Digits are scanned one slot per
//   SCAN_DIV clocks, with optional leading-zero blanking and blinking.
//
//   Parameters:
//     SCAN_DIV      : clocks per digit slot
//     BLINK_DIV     : clocks per blink half-period
//     BLANK_LEADING : 1 = blank leading zeros, 0 = show all digits
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     seg_value  : value to display (unsigned, 24 bits)
//     blink      : level, 1 = flash the display
//     seg_an     : digit enables, active-low, bit 0 = rightmost digit
//     seg_out    : segments, active-low, [0]=a .. [6]=g, [7]=dp
//     conv_busy  : a conversion is in progress
// -----------------------------------------------------------------------------
module seg_display_driver
  import seg_display_driver_pkg::*;
#(
  parameter int SCAN_DIV      = 100_000,
  parameter int BLINK_DIV     = 25_000_000,
  parameter int BLANK_LEADING = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  seg_value,
  input  logic              blink,
  output logic [7:0]        seg_an,
  output logic [7:0]        seg_out,
  output logic              conv_busy
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Conversion control
  logic [BIN_W-1:0]  last_value;
  logic [BCD_W-1:0]  digit_reg;
  logic              conv_start;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  conv_state_e       conv_state;

  // Scan / blink
  logic [SCAN_W-1:0]     scan_cnt;
  logic [2:0]            scan_idx;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_phase;

  // Next output values
  logic [NUM_DIGITS-1:0] blank_vec;
  logic [3:0]            cur_digit;
  logic [7:0]            seg_an_d;
  logic [7:0]            seg_out_d;

  // A change is only looked at while the converter is idle; anything that
  // arrives mid-conversion is picked up on the first idle cycle because
  // last_value still holds the value being converted.
  assign conv_start = (conv_state == CONV_IDLE) && (seg_value != last_value);

  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .rst       (rst),
    .start     (conv_start),
    .value     (seg_value),
    .busy      (conv_busy),
    .done      (conv_done),
    .bcd       (conv_bcd),
    .state_dbg (conv_state)
  );

  // Digit i (i >= 1) is a leading zero when it and every digit above it is
  // zero. Digit 0 is never blanked so a value of 0 still shows "0".
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    blank_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero     = all_zero && (digit_reg[4*i +: 4] == 4'd0);
      blank_vec[i] = (BLANK_LEADING != 0) && all_zero;
    end
  end

  always_comb begin
    cur_digit = digit_reg[{scan_idx, 2'b00} +: 4];
    seg_out_d = blank_vec[scan_idx] ? SEG_BLANK : seg_decode(cur_digit);
    // Blink only gates the anodes; blanked digits still get their anode.
    if (blink && blink_phase) begin
      seg_an_d = 8'hFF;
    end else begin
      seg_an_d = ~(8'b0000_0001 << scan_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_value  <= '0;
      digit_reg   <= '0;
      scan_cnt    <= '0;
      scan_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      seg_an      <= 8'hFF;
      seg_out     <= 8'hFF;
    end else begin
      if (conv_start) begin
        last_value <= seg_value;
      end
      if (conv_done) begin
        digit_reg <= conv_bcd;
      end

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end

      // Registered from the current index and digits, so a digit update and
      // a scan step on the same edge are both visible together next cycle.
      seg_an  <= seg_an_d;
      seg_out <= seg_out_d;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
module tb_seg_display_driver;

  logic        clk;
  logic        rst;
  logic [23:0] seg_value;
  logic        blink;
  logic [7:0]  seg_an_a, seg_out_a;
  logic [7:0]  seg_an_b, seg_out_b;
  logic        busy_a, busy_b;

  int total;
  int bad;

  logic [7:0] cap[8];

  seg_display_driver #(.SCAN_DIV(4), .BLINK_DIV(64), .BLANK_LEADING(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_value (seg_value),
    .blink     (blink),
    .seg_an    (seg_an_a),
    .seg_out   (seg_out_a),
    .conv_busy (busy_a)
  );

  seg_display_driver #(.SCAN_DIV(4), .BLINK_DIV(64), .BLANK_LEADING(0)) dut_nolz (
    .clk       (clk),
    .rst       (rst),
    .seg_value (seg_value),
    .blink     (blink),
    .seg_an    (seg_an_b),
    .seg_out   (seg_out_b),
    .conv_busy (busy_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Waits (bounded) for busy to rise, then counts busy samples until it drops.
  task automatic wait_conv(output int len);
    int n;
    n   = 0;
    len = 0;
    while (busy_a !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    while (busy_a === 1'b1 && len < 100) begin
      len++;
      @(negedge clk);
    end
  endtask

  // Records the segment pattern seen for each digit over a full scan round.
  task automatic scan_capture(input bit use_nolz);
    logic [7:0] an, so;
    for (int d = 0; d < 8; d++) cap[d] = 8'h00;
    repeat (40) begin
      @(negedge clk);
      an = use_nolz ? seg_an_b  : seg_an_a;
      so = use_nolz ? seg_out_b : seg_out_a;
      for (int d = 0; d < 8; d++) begin
        if (an == ~(8'b0000_0001 << d)) cap[d] = so;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [7:0] want[8];
    want = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (seg_an_a !== 8'hFF) begin bad++; $display("FAIL reset_an: got %h want ff", seg_an_a); end
    total++; if (seg_out_a !== 8'hFF) begin bad++; $display("FAIL reset_out: got %h want ff", seg_out_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (seg_an_a !== 8'hFE) begin bad++; $display("FAIL first_slot_an: got %h want fe", seg_an_a); end
    total++; if (seg_out_a !== 8'hC0) begin bad++; $display("FAIL first_slot_out: got %h want c0", seg_out_a); end
    scan_capture(1'b0);
    for (int d = 0; d < 8; d++) begin
      total++;
      if (cap[d] !== want[d]) begin bad++; $display("FAIL reset_digit%0d: got %h want %h", d, cap[d], want[d]); end
    end
  endtask

  task automatic test_1234;
    int len;
    logic [7:0] want[8];
    want = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    seg_value = 24'd1234;
    wait_conv(len);
    total++; if (len != 24) begin bad++; $display("FAIL busy_len_1234: got %0d want 24", len); end
    total++; if (dut.digit_reg !== 32'h0000_1234) begin bad++; $display("FAIL digits_1234: got %h want 00001234", dut.digit_reg); end
    @(negedge clk);
    scan_capture(1'b0);
    for (int d = 0; d < 8; d++) begin
      total++;
      if (cap[d] !== want[d]) begin bad++; $display("FAIL scan_1234_d%0d: got %h want %h", d, cap[d], want[d]); end
    end
  endtask

  task automatic test_max;
    int len;
    logic [7:0] want[8];
    // digits 0..7 = 5,1,2,7,7,7,6,1
    want = '{8'h92, 8'hF9, 8'hA4, 8'hF8, 8'hF8, 8'hF8, 8'h82, 8'hF9};
    seg_value = 24'd16_777_215;
    wait_conv(len);
    total++; if (len != 24) begin bad++; $display("FAIL busy_len_max: got %0d want 24", len); end
    total++; if (dut.digit_reg !== 32'h1677_7215) begin bad++; $display("FAIL digits_max: got %h want 16777215", dut.digit_reg); end
    @(negedge clk);
    scan_capture(1'b0);
    for (int d = 0; d < 8; d++) begin
      total++;
      if (cap[d] !== want[d]) begin bad++; $display("FAIL scan_max_d%0d: got %h want %h", d, cap[d], want[d]); end
    end
  endtask

  task automatic test_no_blanking;
    int len;
    seg_value = 24'd5;
    wait_conv(len);
    total++; if (len != 24) begin bad++; $display("FAIL busy_len_5: got %0d want 24", len); end
    total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL nolz_busy: got %b want 0", busy_b); end
    @(negedge clk);
    scan_capture(1'b1);
    total++; if (cap[0] !== 8'h92) begin bad++; $display("FAIL nolz_d0: got %h want 92", cap[0]); end
    for (int d = 1; d < 8; d++) begin
      total++;
      if (cap[d] !== 8'hC0) begin bad++; $display("FAIL nolz_d%0d: got %h want c0", d, cap[d]); end
    end
    scan_capture(1'b0);
    total++; if (cap[0] !== 8'h92) begin bad++; $display("FAIL lz5_d0: got %h want 92", cap[0]); end
    total++; if (cap[1] !== 8'hFF) begin bad++; $display("FAIL lz5_d1: got %h want ff", cap[1]); end
  endtask

  task automatic test_change_mid_conversion;
    int len, n;
    bit held;
    logic [7:0] want[8];
    want = '{8'hC0, 8'hC0, 8'hA4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    held = 1'b1;
    seg_value = 24'd100;
    @(negedge clk);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL mid_busy_rise: got %b want 1", busy_a); end
    repeat (5) begin
      @(negedge clk);
      if (dut.digit_reg !== 32'h0000_0005) held = 1'b0;
    end
    seg_value = 24'd200;
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      if (dut.digit_reg !== 32'h0000_0005) held = 1'b0;
      @(negedge clk);
      n++;
    end
    total++; if (!held) begin bad++; $display("FAIL mid_partial_shown: got changed want held 00000005"); end
    total++; if (dut.digit_reg !== 32'h0000_0100) begin bad++; $display("FAIL mid_first: got %h want 00000100", dut.digit_reg); end
    @(negedge clk);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL mid_restart: got %b want 1", busy_a); end
    held = 1'b1;
    len = 0;
    while (busy_a === 1'b1 && len < 100) begin
      if (dut.digit_reg !== 32'h0000_0100) held = 1'b0;
      len++;
      @(negedge clk);
    end
    total++; if (len != 24) begin bad++; $display("FAIL mid_second_len: got %0d want 24", len); end
    total++; if (!held) begin bad++; $display("FAIL mid_second_partial: got changed want held 00000100"); end
    total++; if (dut.digit_reg !== 32'h0000_0200) begin bad++; $display("FAIL mid_second: got %h want 00000200", dut.digit_reg); end
    @(negedge clk);
    scan_capture(1'b0);
    for (int d = 0; d < 8; d++) begin
      total++;
      if (cap[d] !== want[d]) begin bad++; $display("FAIL scan_200_d%0d: got %h want %h", d, cap[d], want[d]); end
    end
  endtask

  task automatic test_blink;
    bit off, prev_off, first;
    int run, runs_checked, offs;
    blink = 1'b1;
    repeat (2) @(negedge clk);
    prev_off = (seg_an_a === 8'hFF);
    run = 1;
    first = 1'b1;
    runs_checked = 0;
    repeat (320) begin
      @(negedge clk);
      off = (seg_an_a === 8'hFF);
      if (!off) begin
        total++;
        if ($countones(~seg_an_a) != 1) begin bad++; $display("FAIL blink_onehot: got %h want one low bit", seg_an_a); end
      end
      if (off == prev_off) begin
        run++;
      end else begin
        if (!first) begin
          runs_checked++;
          total++;
          if (run != 64) begin bad++; $display("FAIL blink_run: got %0d want 64 (off=%0b)", run, prev_off); end
        end
        first = 1'b0;
        run = 1;
        prev_off = off;
      end
    end
    total++; if (runs_checked < 3) begin bad++; $display("FAIL blink_runs: got %0d want >=3", runs_checked); end
    blink = 1'b0;
    repeat (2) @(negedge clk);
    offs = 0;
    repeat (200) begin
      @(negedge clk);
      if (seg_an_a === 8'hFF) offs++;
    end
    total++; if (offs != 0) begin bad++; $display("FAIL noblink_off: got %0d want 0", offs); end
  endtask

  task automatic test_reset_mid_conversion;
    int len;
    logic [7:0] want[8];
    want = '{8'hF8, 8'hF8, 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    seg_value = 24'd777;
    @(negedge clk);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL rmid_busy_rise: got %b want 1", busy_a); end
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy_a); end
    total++; if (dut.digit_reg !== 32'h0) begin bad++; $display("FAIL rmid_digits: got %h want 00000000", dut.digit_reg); end
    total++; if (seg_an_a !== 8'hFF) begin bad++; $display("FAIL rmid_an: got %h want ff", seg_an_a); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL rmid_restart: got %b want 1", busy_a); end
    wait_conv(len);
    total++; if (len != 24) begin bad++; $display("FAIL rmid_len: got %0d want 24", len); end
    total++; if (dut.digit_reg !== 32'h0000_0777) begin bad++; $display("FAIL rmid_result: got %h want 00000777", dut.digit_reg); end
    @(negedge clk);
    scan_capture(1'b0);
    for (int d = 0; d < 8; d++) begin
      total++;
      if (cap[d] !== want[d]) begin bad++; $display("FAIL scan_777_d%0d: got %h want %h", d, cap[d], want[d]); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    seg_value = 24'd0;
    blink     = 1'b0;
    test_reset();
    test_1234();
    test_max();
    test_no_blanking();
    test_change_mid_conversion();
    test_blink();
    test_reset_mid_conversion();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
